load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and the byte-addressed, big-endian data memory.
- Memory side: 32-bit word read/write ports, registered read data, one-cycle read latency.
- Converts CPU load/store requests (byte, halfword, word; signed or unsigned) into aligned word accesses.
- Sub-word stores use read-modify-write. Misaligned and out-of-range requests are rejected without touching memory.

Parameters:
- MEM_BYTES, 256, size of data memory in bytes; valid word-aligned addresses are 0..MEM_BYTES-4.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present; accepted when req_valid && req_ready at rising edge
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  input  1  loads only: 1 sign-extends, 0 zero-extends
- req_addr  input  32  byte address
- req_wdata  input  32  store data, sub-word values right-justified in LSBs
- req_ready  output  1  high when state = IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  high with done when the request was rejected
- load_data  output  32  extended load result, valid with done, held until the next load completes
- mem_read  output  1  to data memory read enable
- mem_write  output  1  to data memory write enable
- mem_addr  output  32  word-aligned address (req_addr with bits [1:0] cleared)
- mem_wdata  output  32  word to write
- mem_rdata  input  32  registered read data from memory, valid the cycle after the edge that sampled mem_read

Behaviour:
- Reset values: state IDLE; req_ready 1; done 0; err 0; load_data 0; mem_read 0; mem_write 0; mem_addr 0; mem_wdata 0.
- Request fields are captured at acceptance. Later input changes are ignored.
- Byte lanes are big-endian:
  - Byte offset k = addr[1:0] maps to bits [31-8k : 24-8k].
  - Halfword offset 0 maps to [31:16]; offset 2 maps to [15:0].
- Error check at acceptance:
  - halfword with addr[0] = 1, or word with addr[1:0] != 0 (misaligned);
  - req_size = 11;
  - aligned address > MEM_BYTES-4 (out of range).
  - Result: done = 1 and err = 1 in the next cycle. State stays IDLE. No mem_read or mem_write is ever asserted. load_data is unchanged.
- States: IDLE, RD_REQ, RD_CAPT, WR.
  - mem_read is high only in RD_REQ; mem_write is high only in WR; never both.
  - mem_addr is stable from RD_REQ through WR.
- Load: IDLE -> RD_REQ -> RD_CAPT -> IDLE.
  - Lane extraction and extension happen at the RD_CAPT exit edge.
  - Accepted at edge 1: done and load_data appear in cycle 3.
- Word store: IDLE -> WR, with mem_wdata = req_wdata. Done in cycle 2.
- Sub-word store: IDLE -> RD_REQ -> RD_CAPT -> WR -> IDLE.
  - At the RD_CAPT exit, mem_wdata = mem_rdata with the target lane(s) replaced by req_wdata[7:0] or [15:0].
  - Done in cycle 4.
- done and err last exactly one cycle.
  - State is already IDLE during the done cycle, so req_ready is 1 and a back-to-back request is accepted.
- Reset mid-operation: the next cycle is IDLE with all outputs at their reset values, and the operation is abandoned.
  - Reset asserted in RD_REQ or RD_CAPT: the memory is never written.
  - Reset asserted in a WR cycle: the write still lands, because the memory itself has no reset. No done is issued.
- The memory side needs no handshake; fixed latency is relied upon.

Test Plan:
1. Preload word 0x10 = 0x8899AABB; load word 0x10 -> mem_read in cycle 1 only, done in cycle 3, load_data = 0x8899AABB, err = 0.
2. Signed byte 0x11 -> 0xFFFFFF99; unsigned byte 0x13 -> 0x000000BB; signed half 0x12 -> 0xFFFFAABB; unsigned half 0x10 -> 0x00008899.
3. Byte store 0x12 with req_wdata = 0x000000CC -> mem_read cycle 1; mem_write cycle 3 with mem_addr = 0x10, mem_wdata = 0x8899CCBB; done cycle 4. A following word load returns 0x8899CCBB.
4. Word store 0x11; half load 0x13; size 11; word load 0xFE (MEM_BYTES = 256) -> each gives done = err = 1 in the next cycle, zero mem_read/mem_write activity, load_data unchanged.
5. Reset in the RD_CAPT cycle of a half store to 0x10 -> IDLE next cycle, mem_write never high, done never high, memory still 0x8899AABB.
6. Word store 0x20 = 0x12345678, then a word load 0x20 presented in the done cycle -> load accepted immediately, done 3 cycles later, load_data = 0x12345678.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// The LSU takes the slave side; the CPU/memory environment takes the master side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata, mem_rdata,
        output req_ready, done, err, load_data,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata, mem_rdata,
        input  req_ready, done, err, load_data,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a big-endian word memory,
// sub-word stores done as read-modify-write.
module load_store_unit #(
    parameter int MEM_BYTES = 256
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_CAPT, WR} state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_t      state;
    state_t      state_nx;
    logic        accept;
    logic        bad;
    logic        misalign;
    logic [31:0] aligned;

    logic        r_write;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_load;
    logic        r_done;
    logic        r_err;

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext;
    logic [31:0] merged;

    always_comb begin
        aligned  = {bus.req_addr[31:2], 2'b00};
        misalign = 1'b0;
        unique case (1'b1)
            bus.req_size == 2'b01: misalign = bus.req_addr[0];
            bus.req_size == 2'b10: misalign = |bus.req_addr[1:0];
            bus.req_size == 2'b11: misalign = 1'b1;
            default:               misalign = 1'b0;
        endcase
        bad    = misalign || (aligned > LAST_WORD);
        accept = bus.req_valid && (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && !bad) begin
                    if (bus.req_write && bus.req_size == 2'b10)
                        state_nx = WR;
                    else
                        state_nx = RD_REQ;
                end
            end
            RD_REQ:  state_nx = RD_CAPT;
            RD_CAPT: state_nx = r_write ? WR : IDLE;
            WR:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.mem_read  = (state == RD_REQ);
        bus.mem_write = (state == WR);
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.done      = r_done;
        bus.err       = r_err;
        bus.load_data = r_load;
    end

    // Big-endian lanes: byte k sits (3-k)*8 bits up, halfword 0 is the upper half.
    always_comb begin
        byte_sh = {~r_off, 3'b000};
        half_sh = r_off[1] ? 5'd0 : 5'd16;
        rd_byte = 8'(bus.mem_rdata >> byte_sh);
        rd_half = 16'(bus.mem_rdata >> half_sh);
        unique case (1'b1)
            r_size == 2'b00: begin
                ext    = {{24{r_signed & rd_byte[7]}}, rd_byte};
                merged = (bus.mem_rdata & ~(32'h0000_00FF << byte_sh))
                       | ({24'd0, r_wdata[7:0]} << byte_sh);
            end
            r_size == 2'b01: begin
                ext    = {{16{r_signed & rd_half[15]}}, rd_half};
                merged = (bus.mem_rdata & ~(32'h0000_FFFF << half_sh))
                       | ({16'd0, r_wdata[15:0]} << half_sh);
            end
            default: begin
                ext    = bus.mem_rdata;
                merged = bus.mem_rdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= 2'b00;
            r_off    <= 2'b00;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_load   <= 32'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && bad) begin
                        r_done <= 1'b1;
                        r_err  <= 1'b1;
                    end else if (accept) begin
                        r_write  <= bus.req_write;
                        r_signed <= bus.req_signed;
                        r_size   <= bus.req_size;
                        r_off    <= bus.req_addr[1:0];
                        r_addr   <= aligned;
                        r_wdata  <= bus.req_wdata;
                    end
                end
                RD_CAPT: begin
                    if (r_write) begin
                        r_wdata <= merged;
                    end else begin
                        r_load <= ext;
                        r_done <= 1'b1;
                    end
                end
                WR:      r_done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus back-to-back
// and reset-during-RMW sequences against a small word memory model.
module tb_load_store_unit;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    load_store_unit_if bus();

    load_store_unit #(.MEM_BYTES(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_data;

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_idx] <= poke_data;
        else if (bus.mem_write)
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        if (bus.mem_read)
            bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_ld;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t v [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_idx  = addr[7:2];
        poke_data = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run(input vec_t t);
        int c;
        int rd;
        int wr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        e;
        c = 0; rd = 0; wr = 0; wa = 0; wd = 0; e = 0;
        chk({t.name, " ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = t.wr;
        bus.req_size   = t.sz;
        bus.req_signed = t.sgn;
        bus.req_addr   = t.addr;
        bus.req_wdata  = t.wdata;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_write  = ~t.wr;
        bus.req_signed = ~t.sgn;
        bus.req_addr   = 32'hDEAD_BEEF;
        bus.req_wdata  = 32'hFFFF_FFFF;
        do begin
            @(negedge clk);
            c++;
            if (bus.mem_read) rd++;
            if (bus.mem_write) begin
                wr++;
                wa = bus.mem_addr;
                wd = bus.mem_wdata;
            end
            e = bus.err;
        end while (!bus.done && c < 10);
        chk({t.name, " latency"}, 32'(c), 32'(t.exp_lat));
        chk({t.name, " err"}, 32'(e), 32'(t.exp_err));
        chk({t.name, " load_data"}, bus.load_data, t.exp_ld);
        chk({t.name, " reads"}, 32'(rd), 32'(t.exp_rd));
        chk({t.name, " writes"}, 32'(wr), 32'(t.exp_wr));
        if (t.exp_wr != 0) begin
            chk({t.name, " mem_addr"}, wa, t.exp_wa);
            chk({t.name, " mem_wdata"}, wd, t.exp_wd);
        end
    endtask

    initial begin
        vec_t sw20;
        vec_t lw20;
        vec_t lw10;
        int   nwr;
        int   ndone;
        errors = 0;
        checks = 0;
        poke_en = 1'b0;
        poke_idx = '0;
        poke_data = '0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;

        v[0]  = '{"lw 10",   0, 2'b10, 0, 32'h10,  32'h0,         0, 3, 32'h8899AABB, 1, 0, 0, 0};
        v[1]  = '{"lb 11",   0, 2'b00, 1, 32'h11,  32'h0,         0, 3, 32'hFFFFFF99, 1, 0, 0, 0};
        v[2]  = '{"lbu 13",  0, 2'b00, 0, 32'h13,  32'h0,         0, 3, 32'h000000BB, 1, 0, 0, 0};
        v[3]  = '{"lh 12",   0, 2'b01, 1, 32'h12,  32'h0,         0, 3, 32'hFFFFAABB, 1, 0, 0, 0};
        v[4]  = '{"lhu 10",  0, 2'b01, 0, 32'h10,  32'h0,         0, 3, 32'h00008899, 1, 0, 0, 0};
        v[5]  = '{"sb 12",   1, 2'b00, 0, 32'h12,  32'h000000CC,  0, 4, 32'h00008899, 1, 1,
                  32'h10, 32'h8899CCBB};
        v[6]  = '{"lw 10b",  0, 2'b10, 0, 32'h10,  32'h0,         0, 3, 32'h8899CCBB, 1, 0, 0, 0};
        v[7]  = '{"sw 11",   1, 2'b10, 0, 32'h11,  32'h01020304,  1, 1, 32'h8899CCBB, 0, 0, 0, 0};
        v[8]  = '{"lh 13",   0, 2'b01, 1, 32'h13,  32'h0,         1, 1, 32'h8899CCBB, 0, 0, 0, 0};
        v[9]  = '{"size 11", 0, 2'b11, 0, 32'h10,  32'h0,         1, 1, 32'h8899CCBB, 0, 0, 0, 0};
        v[10] = '{"lw fe",   0, 2'b10, 0, 32'hFE,  32'h0,         1, 1, 32'h8899CCBB, 0, 0, 0, 0};
        v[11] = '{"lw 100",  0, 2'b10, 0, 32'h100, 32'h0,         1, 1, 32'h8899CCBB, 0, 0, 0, 0};
        v[12] = '{"lbu ff",  0, 2'b00, 0, 32'hFF,  32'h0,         0, 3, 32'h00000055, 1, 0, 0, 0};
        v[13] = '{"sh 12",   1, 2'b01, 0, 32'h12,  32'hABCD1234,  0, 4, 32'h00000055, 1, 1,
                  32'h10, 32'h88991234};
        v[14] = '{"lh 10",   0, 2'b01, 1, 32'h10,  32'h0,         0, 3, 32'hFFFF8899, 1, 0, 0, 0};
        v[15] = '{"sb 10",   1, 2'b00, 0, 32'h10,  32'hFFFFFF7F,  0, 4, 32'hFFFF8899, 1, 1,
                  32'h10, 32'h7F991234};
        v[16] = '{"lb 10",   0, 2'b00, 1, 32'h10,  32'h0,         0, 3, 32'h0000007F, 1, 0, 0, 0};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst ready", 32'(bus.req_ready), 32'd1);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        chk("rst load_data", bus.load_data, 32'd0);
        chk("rst mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        reset = 1'b0;

        poke(32'h10, 32'h8899AABB);
        poke(32'hFC, 32'h00000055);

        for (int i = 0; i < 17; i++) run(v[i]);

        sw20 = '{"sw 20", 1, 2'b10, 0, 32'h20, 32'h12345678, 0, 2, 32'h0000007F, 0, 1,
                 32'h20, 32'h12345678};
        lw20 = '{"lw 20", 0, 2'b10, 0, 32'h20, 32'h0, 0, 3, 32'h12345678, 1, 0, 0, 0};
        run(sw20);
        run(lw20);

        poke(32'h10, 32'h8899AABB);
        nwr = 0;
        ndone = 0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'b01;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h0000DEAD;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rmw rd_req mem_read", 32'(bus.mem_read), 32'd1);
        @(negedge clk);
        if (bus.mem_write) nwr++;
        if (bus.done) ndone++;
        reset = 1'b1;
        @(negedge clk);
        chk("rmw rst ready", 32'(bus.req_ready), 32'd1);
        chk("rmw rst mem_read", 32'(bus.mem_read), 32'd0);
        chk("rmw rst mem_addr", bus.mem_addr, 32'd0);
        chk("rmw rst mem_wdata", bus.mem_wdata, 32'd0);
        chk("rmw rst load_data", bus.load_data, 32'd0);
        reset = 1'b0;
        repeat (4) begin
            if (bus.mem_write) nwr++;
            if (bus.done) ndone++;
            @(negedge clk);
        end
        chk("rmw rst writes", 32'(nwr), 32'd0);
        chk("rmw rst dones", 32'(ndone), 32'd0);
        lw10 = '{"lw 10 after rst", 0, 2'b10, 0, 32'h10, 32'h0, 0, 3, 32'h8899AABB, 1, 0, 0, 0};
        run(lw10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
